// File: rtl/pipeline_pkg.sv
// Shared instruction field positions and the per-stage control record of the load/store pipeline.
package pipeline_pkg;

    localparam int unsigned ST_BIT      = 31;
    localparam int unsigned LD_BIT      = 30;
    localparam int unsigned REG1_LSB    = 27;
    localparam int unsigned REG2_LSB    = 24;
    localparam int unsigned WREG_LSB    = 21;
    localparam int unsigned HALT_BIT    = 20;
    localparam int unsigned REG_FIELD_W = 3;

    typedef struct packed {
        logic                   valid;
        logic                   ld;
        logic                   st;
        logic                   halt;
        logic [REG_FIELD_W-1:0] wreg;
    } stage_ctrl_t;

    function automatic stage_ctrl_t decode(input logic valid, input logic [31:0] instr);
        stage_ctrl_t d;
        d.valid = valid;
        d.ld    = instr[LD_BIT];
        d.st    = instr[ST_BIT];
        d.halt  = instr[HALT_BIT];
        d.wreg  = instr[WREG_LSB +: REG_FIELD_W];
        return d;
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit.sv
// Load-use interlock: stall ID while a valid LOAD in EX or MEM targets a register ID reads.
module pipeline_hazard_unit
    import pipeline_pkg::*;
#(
    parameter int unsigned NREG = 4
) (
    input  logic                   id_valid,
    input  logic                   id_st,
    input  logic [REG_FIELD_W-1:0] id_reg1,
    input  logic [REG_FIELD_W-1:0] id_reg2,
    input  stage_ctrl_t            ex_ctrl,
    input  stage_ctrl_t            mem_ctrl,
    output logic                   stall
);

    localparam logic [REG_FIELD_W-1:0] REG_MASK = REG_FIELD_W'(NREG - 1);

    function automatic logic load_hit(input stage_ctrl_t s, input logic [REG_FIELD_W-1:0] r);
        return s.valid && s.ld && ((s.wreg & REG_MASK) == (r & REG_MASK));
    endfunction

    logic unused_fields;
    assign unused_fields = ^{ex_ctrl.st, ex_ctrl.halt, mem_ctrl.st, mem_ctrl.halt};

    always_comb begin
        stall = 1'b0;
        if (id_valid) begin
            stall = load_hit(ex_ctrl, id_reg1) || load_hit(mem_ctrl, id_reg1) ||
                    (id_st && (load_hit(ex_ctrl, id_reg2) || load_hit(mem_ctrl, id_reg2)));
        end
    end

endmodule

// File: rtl/pipeline_param.sv
// Parametrised 5-stage LOAD/STORE/HALT pipeline with run/step control, host programming ports,
// load-use interlock with WB-to-ID bypass, and performance counters.
module pipeline_param
    import pipeline_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned NREG    = 4,
    parameter int unsigned IMEM_AW = 9,
    parameter int unsigned DMEM_AW = 8,
    parameter int unsigned CNT_W   = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               run,
    input  logic               step,
    input  logic               pc_reset_pulse,
    input  logic               imem_prog_we,
    input  logic [IMEM_AW-1:0] imem_prog_addr,
    input  logic [31:0]        imem_prog_wdata,
    input  logic               dmem_prog_en,
    input  logic               dmem_prog_we,
    input  logic [DMEM_AW-1:0] dmem_prog_addr,
    input  logic [DATA_W-1:0]  dmem_prog_wdata,
    output logic [DATA_W-1:0]  dmem_prog_rdata,
    output logic               halted,
    output logic [IMEM_AW-1:0] pc_dbg,
    output logic [31:0]        if_instr_dbg,
    output logic [CNT_W-1:0]   cycle_cnt,
    output logic [CNT_W-1:0]   retired_cnt,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int unsigned REG_AW = $clog2(NREG);

    logic [31:0]        imem [2**IMEM_AW];
    logic [DATA_W-1:0]  dmem [2**DMEM_AW];
    logic [DATA_W-1:0]  rf_q [NREG];

    logic               step_d_q, halted_q, fetch_stop_q, if_valid_q;
    logic [IMEM_AW-1:0] pc_q;
    logic [31:0]        if_instr_q;
    stage_ctrl_t        ex_q, mem_q, wb_q, id_ctrl;
    logic [DMEM_AW-1:0] ex_addr_q, mem_addr_q, id_addr;
    logic [DATA_W-1:0]  ex_data_q, mem_data_q, wb_rdata_q, prog_rdata_q, id_data;
    logic [CNT_W-1:0]   cycle_cnt_q, retired_cnt_q, stall_cnt_q;
    logic [REG_AW-1:0]  id_reg1, id_reg2, wb_wreg;
    logic               adv, stall, fetch_stop, wb_fwd;

    assign adv        = (run | (step & ~step_d_q)) & ~halted_q & ~imem_prog_we;
    assign id_ctrl    = decode(if_valid_q, if_instr_q);
    assign id_reg1    = if_instr_q[REG1_LSB +: REG_AW];
    assign id_reg2    = if_instr_q[REG2_LSB +: REG_AW];
    assign wb_wreg    = wb_q.wreg[REG_AW-1:0];
    assign wb_fwd     = wb_q.valid && wb_q.ld;
    assign fetch_stop = fetch_stop_q || (id_ctrl.valid && id_ctrl.halt);

    logic unused_wb;
    assign unused_wb = ^{wb_q.st, wb_q.wreg};

    // Write-through: a LOAD retiring in WB is seen by the ID register read this cycle.
    always_comb begin
        id_addr = rf_q[id_reg1][DMEM_AW-1:0];
        id_data = rf_q[id_reg2];
        if (wb_fwd && wb_wreg == id_reg1) id_addr = wb_rdata_q[DMEM_AW-1:0];
        if (wb_fwd && wb_wreg == id_reg2) id_data = wb_rdata_q;
    end

    pipeline_hazard_unit #(
        .NREG(NREG)
    ) u_hazard (
        .id_valid (id_ctrl.valid),
        .id_st    (id_ctrl.st),
        .id_reg1  (if_instr_q[REG1_LSB +: REG_FIELD_W]),
        .id_reg2  (if_instr_q[REG2_LSB +: REG_FIELD_W]),
        .ex_ctrl  (ex_q),
        .mem_ctrl (mem_q),
        .stall    (stall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            step_d_q      <= 1'b0;
            halted_q      <= 1'b0;
            fetch_stop_q  <= 1'b0;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            pc_q          <= '0;
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else if (pc_reset_pulse) begin
            step_d_q      <= 1'b0;
            halted_q      <= 1'b0;
            fetch_stop_q  <= 1'b0;
            if_valid_q    <= 1'b0;
            if_instr_q    <= '0;
            pc_q          <= '0;
            ex_q          <= '0;
            mem_q         <= '0;
            wb_q          <= '0;
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
            stall_cnt_q   <= '0;
        end else begin
            step_d_q <= step;
            if (adv) begin
                cycle_cnt_q <= cycle_cnt_q + CNT_W'(1);
                if (stall) begin
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                    ex_q        <= '0;
                end else begin
                    ex_q <= id_ctrl;
                    if (id_ctrl.valid && id_ctrl.halt) fetch_stop_q <= 1'b1;
                    if (fetch_stop) begin
                        if_valid_q <= 1'b0;
                        if_instr_q <= '0;
                    end else begin
                        if_valid_q <= 1'b1;
                        if_instr_q <= imem[pc_q];
                        pc_q       <= pc_q + IMEM_AW'(1);
                    end
                end
                mem_q <= ex_q;
                wb_q  <= mem_q;
                if (wb_q.valid) retired_cnt_q <= retired_cnt_q + CNT_W'(1);
                if (wb_q.valid && wb_q.halt) halted_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv && !stall) begin
            ex_addr_q <= id_addr;
            ex_data_q <= id_data;
        end
        if (adv) begin
            mem_addr_q <= ex_addr_q;
            mem_data_q <= ex_data_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
        end else if (pc_reset_pulse) begin
            for (int i = 0; i < int'(NREG); i++) rf_q[i] <= '0;
        end else if (adv && wb_fwd) begin
            rf_q[wb_wreg] <= wb_rdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (imem_prog_we) imem[imem_prog_addr] <= imem_prog_wdata;
    end

    // Port B is written first so a same-cycle port A store to the same word wins.
    always_ff @(posedge clk) begin
        if (dmem_prog_en && dmem_prog_we) dmem[dmem_prog_addr] <= dmem_prog_wdata;
        if (adv && mem_q.valid && mem_q.st) dmem[mem_addr_q] <= mem_data_q;
        if (adv) wb_rdata_q <= dmem[mem_addr_q];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prog_rdata_q <= '0;
        end else if (pc_reset_pulse) begin
            prog_rdata_q <= '0;
        end else if (dmem_prog_en) begin
            prog_rdata_q <= dmem[dmem_prog_addr];
        end
    end

    assign dmem_prog_rdata = prog_rdata_q;
    assign halted          = halted_q;
    assign pc_dbg          = pc_q;
    assign if_instr_dbg    = if_instr_q;
    assign cycle_cnt       = cycle_cnt_q;
    assign retired_cnt     = retired_cnt_q;
    assign stall_cnt       = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_param.sv
// Directed bench for pipeline_param: reset, loads/stores, load-use stalls, step, HALT, collisions.
module tb_pipeline_param;

    localparam int unsigned DATA_W  = 64;
    localparam int unsigned IMEM_AW = 9;
    localparam int unsigned DMEM_AW = 8;
    localparam int unsigned CNT_W   = 32;
    localparam logic [31:0] HALT_I  = 32'h0010_0000;

    logic               clk = 1'b0;
    logic               reset_n, run, step, pc_reset_pulse;
    logic               imem_prog_we;
    logic [IMEM_AW-1:0] imem_prog_addr;
    logic [31:0]        imem_prog_wdata;
    logic               dmem_prog_en, dmem_prog_we;
    logic [DMEM_AW-1:0] dmem_prog_addr;
    logic [DATA_W-1:0]  dmem_prog_wdata, dmem_prog_rdata;
    logic               halted;
    logic [IMEM_AW-1:0] pc_dbg;
    logic [31:0]        if_instr_dbg;
    logic [CNT_W-1:0]   cycle_cnt, retired_cnt, stall_cnt;

    int n_checks = 0;
    int n_errors = 0;
    logic [DATA_W-1:0] rd;

    pipeline_param dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .run             (run),
        .step            (step),
        .pc_reset_pulse  (pc_reset_pulse),
        .imem_prog_we    (imem_prog_we),
        .imem_prog_addr  (imem_prog_addr),
        .imem_prog_wdata (imem_prog_wdata),
        .dmem_prog_en    (dmem_prog_en),
        .dmem_prog_we    (dmem_prog_we),
        .dmem_prog_addr  (dmem_prog_addr),
        .dmem_prog_wdata (dmem_prog_wdata),
        .dmem_prog_rdata (dmem_prog_rdata),
        .halted          (halted),
        .pc_dbg          (pc_dbg),
        .if_instr_dbg    (if_instr_dbg),
        .cycle_cnt       (cycle_cnt),
        .retired_cnt     (retired_cnt),
        .stall_cnt       (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] enc_ld(input int w, input int r1);
        return (32'd1 << 30) | (32'(r1) << 27) | (32'(w) << 21);
    endfunction

    function automatic logic [31:0] enc_st(input int r1, input int r2);
        return (32'd1 << 31) | (32'(r1) << 27) | (32'(r2) << 24);
    endfunction

    task automatic imem_wr(input int addr, input logic [31:0] data);
        imem_prog_we    = 1'b1;
        imem_prog_addr  = IMEM_AW'(addr);
        imem_prog_wdata = data;
        tick();
        imem_prog_we = 1'b0;
    endtask

    task automatic dmem_wr(input int addr, input logic [DATA_W-1:0] data);
        dmem_prog_en    = 1'b1;
        dmem_prog_we    = 1'b1;
        dmem_prog_addr  = DMEM_AW'(addr);
        dmem_prog_wdata = data;
        tick();
        dmem_prog_en = 1'b0;
        dmem_prog_we = 1'b0;
    endtask

    task automatic dmem_rd(input int addr, output logic [DATA_W-1:0] data);
        dmem_prog_en   = 1'b1;
        dmem_prog_we   = 1'b0;
        dmem_prog_addr = DMEM_AW'(addr);
        tick();
        data         = dmem_prog_rdata;
        dmem_prog_en = 1'b0;
    endtask

    task automatic hard_reset();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    // Bounded run; a missing HALT shows up as a failed "halted" check.
    task automatic run_to_halt();
        int n = 0;
        run = 1'b1;
        while (!halted && n < 200) begin
            tick();
            n++;
        end
        run = 1'b0;
        check("halted", 64'(halted), 64'd1);
    endtask

    initial begin
        reset_n = 1'b0; run = 1'b0; step = 1'b0; pc_reset_pulse = 1'b0;
        imem_prog_we = 1'b0; imem_prog_addr = '0; imem_prog_wdata = '0;
        dmem_prog_en = 1'b0; dmem_prog_we = 1'b0; dmem_prog_addr = '0; dmem_prog_wdata = '0;
        repeat (2) tick();
        check("rst_pc", 64'(pc_dbg), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_cycle", 64'(cycle_cnt), 64'd0);
        check("rst_if_instr", 64'(if_instr_dbg), 64'd0);
        check("rst_prog_rdata", dmem_prog_rdata, 64'd0);
        reset_n = 1'b1;

        // Basic loads and stores, with two load-use stalls of two cycles each.
        dmem_wr(0, 64'd5);
        dmem_wr(5, 64'hAAAA);
        dmem_wr(8'hAA, 64'd0);
        imem_wr(0, enc_ld(0, 0));
        imem_wr(1, enc_ld(1, 0));
        imem_wr(2, enc_st(0, 1));
        imem_wr(3, enc_st(1, 0));
        imem_wr(4, HALT_I);
        run_to_halt();
        check("basic_retired", 64'(retired_cnt), 64'd5);
        check("basic_stalls", 64'(stall_cnt), 64'd4);
        check("basic_cycles", 64'(cycle_cnt), 64'd13);
        check("basic_pc", 64'(pc_dbg), 64'd5);
        dmem_rd(5, rd);
        check("basic_dmem5", rd, 64'hAAAA);
        dmem_rd(8'hAA, rd);
        check("basic_dmemAA", rd, 64'd5);

        // Load immediately used as the store address.
        hard_reset();
        dmem_wr(0, 64'h30);
        dmem_wr(8'h30, 64'hDEAD);
        imem_wr(0, enc_ld(2, 0));
        imem_wr(1, enc_st(2, 2));
        imem_wr(2, HALT_I);
        run_to_halt();
        check("lu_stalls", 64'(stall_cnt), 64'd2);
        check("lu_retired", 64'(retired_cnt), 64'd3);
        check("lu_cycles", 64'(cycle_cnt), 64'd9);
        dmem_rd(8'h30, rd);
        check("lu_dmem30", rd, 64'h30);

        // HALT drains older work and blocks the younger STORE.
        hard_reset();
        dmem_wr(0, 64'h40);
        dmem_wr(8'h40, 64'h77);
        imem_wr(0, enc_ld(1, 0));
        imem_wr(1, enc_ld(2, 0));
        imem_wr(2, HALT_I);
        imem_wr(3, enc_st(1, 2));
        run_to_halt();
        check("halt_retired", 64'(retired_cnt), 64'd3);
        check("halt_stalls", 64'(stall_cnt), 64'd0);
        run = 1'b1;
        repeat (5) tick();
        run = 1'b0;
        check("halt_pc_frozen", 64'(pc_dbg), 64'd3);
        check("halt_cycles", 64'(cycle_cnt), 64'd7);
        dmem_rd(8'h40, rd);
        check("halt_no_store", rd, 64'h77);

        // Step mode: a held step advances once; each fresh rising edge advances once more.
        hard_reset();
        step = 1'b1;
        repeat (10) tick();
        check("step_hold_cycles", 64'(cycle_cnt), 64'd1);
        check("step_if_instr", 64'(if_instr_dbg), 64'(enc_ld(1, 0)));
        repeat (3) begin
            step = 1'b0;
            tick();
            step = 1'b1;
            tick();
        end
        step = 1'b0;
        check("step_toggle_cycles", 64'(cycle_cnt), 64'd4);
        check("step_pc", 64'(pc_dbg), 64'd3);

        // Soft reset overrides run and keeps D-mem.
        run_to_halt();
        check("pre_soft_retired", 64'(retired_cnt), 64'd3);
        run = 1'b1;
        pc_reset_pulse = 1'b1;
        tick();
        pc_reset_pulse = 1'b0;
        run = 1'b0;
        check("soft_pc", 64'(pc_dbg), 64'd0);
        check("soft_cycle", 64'(cycle_cnt), 64'd0);
        check("soft_retired", 64'(retired_cnt), 64'd0);
        check("soft_stall", 64'(stall_cnt), 64'd0);
        check("soft_halted", 64'(halted), 64'd0);
        dmem_rd(8'h40, rd);
        check("soft_dmem_kept", rd, 64'h77);

        // Asynchronous reset mid-run takes effect without a clock edge.
        run = 1'b1;
        repeat (3) tick();
        check("mid_run_cycle", 64'(cycle_cnt), 64'd3);
        reset_n = 1'b0;
        #1;
        check("async_pc", 64'(pc_dbg), 64'd0);
        check("async_cycle", 64'(cycle_cnt), 64'd0);
        run = 1'b0;
        tick();
        reset_n = 1'b1;

        // Port A store and port B write hit 0x10 in the same cycle (the 7th advance).
        dmem_wr(0, 64'h10);
        dmem_wr(8'h10, 64'h55);
        imem_wr(0, enc_ld(3, 0));
        imem_wr(1, enc_st(3, 3));
        imem_wr(2, HALT_I);
        run = 1'b1;
        repeat (6) tick();
        dmem_prog_en    = 1'b1;
        dmem_prog_we    = 1'b1;
        dmem_prog_addr  = 8'h10;
        dmem_prog_wdata = 64'hBEEF;
        tick();
        dmem_prog_we = 1'b0;
        tick();
        dmem_prog_en = 1'b0;
        check("collision_port_a_wins", dmem_prog_rdata, 64'h10);
        run_to_halt();
        check("collision_stalls", 64'(stall_cnt), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
